// File: rtl/timer_unit.sv
// ---------------------------------------------------------------------------
// timer_unit
//   Free-running 16-bit divider plus a programmable 8-bit timer (TIMA) with
//   modulo reload (TMA), control register (TAC) and a one-clock interrupt.
//   The TIMA overflow is not reloaded immediately. It waits in an OVF phase
//   for RELOAD_DELAY clocks and is then reloaded in a single RELOAD clock,
//   which is also the only clock in which irq is high.
//
// Ports
//   clk          in   system clock, all state updates on posedge
//   reset        in   synchronous active-high reset
//   addr[1:0]    in   register select: 0=DIV 1=TIMA 2=TMA 3=TAC
//   wr           in   write strobe, one clock per write
//   wdata[7:0]   in   write data
//   rdata[7:0]   out  combinational read data for addr
//   irq          out  timer interrupt, high only in the RELOAD clock
//   dbg_state_o  out  current timer FSM state (0=RUN 1=OVF 2=RELOAD)
//
// Bus handshake: there is no valid/ready pair. A write takes effect on the
// posedge where wr is high; a read is purely combinational from addr.
// ---------------------------------------------------------------------------
module timer_unit #(
  parameter logic [15:0] INITIAL_DIV  = 16'h0000,
  parameter int unsigned RELOAD_DELAY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] addr,
  input  logic       wr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq,
  output logic [1:0] dbg_state_o
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_OVF    = 2'd1;
  localparam logic [1:0] ST_RELOAD = 2'd2;

  localparam logic [3:0] DLY_LAST = 4'(RELOAD_DELAY);

  logic [15:0] div_cnt_q, div_cnt_d;
  logic [7:0]  tima_q, tima_d;
  logic [7:0]  tma_q, tma_d;
  logic [2:0]  tac_q, tac_d;
  logic        sel_q, sel_d;
  logic [1:0]  state_q, state_d;
  logic [3:0]  dly_q, dly_d;

  logic wr_div, wr_tima, wr_tma, wr_tac;
  logic div_bit, sel, tick;

  always_comb begin
    wr_div  = wr && (addr == 2'd0);
    wr_tima = wr && (addr == 2'd1);
    wr_tma  = wr && (addr == 2'd2);
    wr_tac  = wr && (addr == 2'd3);
  end

  // Divider and the timer clock source. tick is a falling edge of the
  // gated selected bit, so clearing DIV, disabling TAC or moving the select
  // to a low bit can all produce an extra tick.
  always_comb begin
    div_cnt_d = wr_div ? 16'h0000 : div_cnt_q + 16'h0001;
    case (tac_q[1:0])
      2'b00:   div_bit = div_cnt_q[9];
      2'b01:   div_bit = div_cnt_q[3];
      2'b10:   div_bit = div_cnt_q[5];
      default: div_bit = div_cnt_q[7];
    endcase
    sel   = div_bit & tac_q[2];
    sel_d = sel;
    tick  = sel_q & ~sel;
    tma_d = wr_tma ? wdata : tma_q;
    tac_d = wr_tac ? wdata[2:0] : tac_q;
  end

  // Timer FSM. tma_d is used as the reload source so that a TMA write in
  // the reload clock passes straight through to TIMA.
  always_comb begin
    tima_d  = tima_q;
    state_d = state_q;
    dly_d   = dly_q;
    case (state_q)
      ST_RUN: begin
        if (wr_tima) begin
          tima_d = wdata;             // write beats a coincident tick
        end else if (tick) begin
          if (tima_q == 8'hFF) begin
            tima_d  = 8'h00;
            state_d = ST_OVF;
            dly_d   = 4'd1;           // the overflow clock is the first delay clock
          end else begin
            tima_d = tima_q + 8'h01;
          end
        end
      end
      ST_OVF: begin
        if (wr_tima) begin
          tima_d  = wdata;            // cancels the pending reload and irq
          state_d = ST_RUN;
          dly_d   = 4'd0;
        end else if (dly_q == DLY_LAST) begin
          tima_d  = tma_d;
          state_d = ST_RELOAD;
          dly_d   = 4'd0;
        end else begin
          dly_d = dly_q + 4'd1;
        end
      end
      ST_RELOAD: begin
        tima_d  = tma_d;              // TIMA writes ignored here
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        dly_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= INITIAL_DIV;
      tima_q    <= 8'h00;
      tma_q     <= 8'h00;
      tac_q     <= 3'b000;
      sel_q     <= 1'b0;
      state_q   <= ST_RUN;
      dly_q     <= 4'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tima_q    <= tima_d;
      tma_q     <= tma_d;
      tac_q     <= tac_d;
      sel_q     <= sel_d;
      state_q   <= state_d;
      dly_q     <= dly_d;
    end
  end

  always_comb begin
    case (addr)
      2'd0:    rdata = div_cnt_q[15:8];
      2'd1:    rdata = tima_q;
      2'd2:    rdata = tma_q;
      default: rdata = {5'b11111, tac_q};
    endcase
  end

  assign irq         = (state_q == ST_RELOAD);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_timer_unit.sv
// ---------------------------------------------------------------------------
// tb_timer_unit
//   Directed bench for timer_unit. Driver tasks issue one bus cycle each;
//   when a cycle carries a check, the expected {state_flag, state, irq, rdata}
//   is pushed into exp_q and the monitor pops and compares it at the negedge.
//   Cycle comments use Ck = the cycle in which the divider holds k after the
//   most recent DIV clear.
// ---------------------------------------------------------------------------
module tb_timer_unit;

  localparam logic [15:0] INIT_DIV = 16'h12F0;
  localparam int          RD       = 4;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_OVF    = 2'd1;
  localparam logic [1:0] ST_RELOAD = 2'd2;

  // ---- clock / reset ------------------------------------------------------
  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] addr  = 2'd0;
  logic       wr    = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       irq;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  timer_unit #(
    .INITIAL_DIV (INIT_DIV),
    .RELOAD_DELAY(RD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .wr         (wr),
    .wdata      (wdata),
    .rdata      (rdata),
    .irq        (irq),
    .dbg_state_o(dbg_state)
  );

  // ---- scoreboard ---------------------------------------------------------
  logic [11:0] exp_q[$];
  string       name_q[$];
  logic        chk_en = 1'b0;
  int          n_vec  = 0;
  int          n_err  = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_empty: DUT rdata=%h irq=%b with no expected entry", rdata, irq);
      end else begin
        logic [11:0] e;
        string       nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (rdata !== e[7:0] || irq !== e[8] || (e[11] && dbg_state !== e[10:9])) begin
          n_err++;
          $display("FAIL %s: got rdata=%h irq=%b state=%0d, expected rdata=%h irq=%b state=%0d%s",
                   nm, rdata, irq, dbg_state, e[7:0], e[8], e[10:9], e[11] ? "" : " (state not checked)");
        end
      end
    end
  end

  // ---- driver tasks -------------------------------------------------------
  task automatic step(input logic w, input logic [1:0] a, input logic [7:0] d,
                      input logic chk, input logic [7:0] e_rd, input logic e_irq,
                      input logic st_chk, input logic [1:0] e_st, input string nm);
    wr    = w;
    addr  = a;
    wdata = d;
    if (chk) begin
      exp_q.push_back({st_chk, e_st, e_irq, e_rd});
      name_q.push_back(nm);
    end
    chk_en = chk;
    @(posedge clk);
    #1;
    wr     = 1'b0;
    chk_en = 1'b0;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    step(1'b1, a, d, 1'b0, 8'h00, 1'b0, 1'b0, ST_RUN, "");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, ST_RUN, "");
  endtask

  task automatic chk(input logic [1:0] a, input logic [7:0] e_rd, input logic e_irq, input string nm);
    step(1'b0, a, 8'h00, 1'b1, e_rd, e_irq, 1'b0, ST_RUN, nm);
  endtask

  task automatic chk_st(input logic [1:0] a, input logic [7:0] e_rd, input logic e_irq,
                        input logic [1:0] e_st, input string nm);
    step(1'b0, a, 8'h00, 1'b1, e_rd, e_irq, 1'b1, e_st, nm);
  endtask

  // Disable the timer, then clear DIV: returns at the start of C0 with no
  // pending tick (sel_q is 0 in C0).
  task automatic setup();
    wr_reg(2'd3, 8'h00);
    wr_reg(2'd0, 8'h00);
  endtask

  // ---- stimulus -----------------------------------------------------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset values
    chk_st(2'd0, INIT_DIV[15:8], 1'b0, ST_RUN, "rst_div");
    chk(2'd1, 8'h00, 1'b0, "rst_tima");
    chk(2'd2, 8'h00, 1'b0, "rst_tma");
    chk(2'd3, 8'hF8, 1'b0, "rst_tac");

    // A: count, overflow, delayed reload with irq
    setup();
    wr_reg(2'd2, 8'h77);                              // C0
    wr_reg(2'd1, 8'hFE);                              // C1
    wr_reg(2'd3, 8'h05);                              // C2
    idle(12);                                         // C3..C14
    chk_st(2'd1, 8'hFE, 1'b0, ST_RUN, "a_c15");
    chk_st(2'd1, 8'hFE, 1'b0, ST_RUN, "a_c16");
    chk_st(2'd1, 8'hFF, 1'b0, ST_RUN, "a_c17");
    idle(14);                                         // C18..C31
    chk_st(2'd1, 8'hFF, 1'b0, ST_RUN, "a_c32");
    for (int i = 0; i < RD; i++) chk_st(2'd1, 8'h00, 1'b0, ST_OVF, "a_ovf");  // C33..C36
    chk_st(2'd1, 8'h77, 1'b1, ST_RELOAD, "a_reload");                        // C37
    chk_st(2'd1, 8'h77, 1'b0, ST_RUN, "a_after");                            // C38

    // B: TIMA write in the second OVF clock cancels reload
    setup();
    wr_reg(2'd2, 8'hA0);
    wr_reg(2'd1, 8'hFF);
    wr_reg(2'd3, 8'h05);
    idle(13);                                         // C3..C15
    chk_st(2'd1, 8'hFF, 1'b0, ST_RUN, "b_c16");
    chk_st(2'd1, 8'h00, 1'b0, ST_OVF, "b_ovf1");
    step(1'b1, 2'd1, 8'h33, 1'b1, 8'h00, 1'b0, 1'b1, ST_OVF, "b_ovf2_write");
    for (int i = 0; i < 5; i++) chk_st(2'd1, 8'h33, 1'b0, ST_RUN, "b_cancel"); // C19..C23

    // C: TMA write in the RELOAD clock writes through to TIMA
    setup();
    wr_reg(2'd2, 8'h11);
    wr_reg(2'd1, 8'hFF);
    wr_reg(2'd3, 8'h05);
    idle(18);                                         // C3..C20
    step(1'b1, 2'd2, 8'h55, 1'b1, 8'h11, 1'b1, 1'b1, ST_RELOAD, "c_reload_tma_wr");
    chk_st(2'd1, 8'h55, 1'b0, ST_RUN, "c_tima");
    chk(2'd2, 8'h55, 1'b0, "c_tma");

    // D: DIV write while the selected bit 9 is high gives one extra tick
    setup();
    wr_reg(2'd1, 8'h40);
    wr_reg(2'd3, 8'h04);
    idle(509);                                        // C2..C510
    chk(2'd1, 8'h40, 1'b0, "d_c511");
    wr_reg(2'd0, 8'h5A);                              // C512, bit9 high
    chk(2'd1, 8'h40, 1'b0, "d_d0");
    chk(2'd1, 8'h41, 1'b0, "d_d1");
    chk(2'd1, 8'h41, 1'b0, "d_d2");

    // E: disabling TAC while the selected bit is high gives one tick
    setup();
    wr_reg(2'd1, 8'h20);
    wr_reg(2'd3, 8'h05);
    idle(6);                                          // C2..C7
    chk(2'd1, 8'h20, 1'b0, "e_c8");
    wr_reg(2'd3, 8'h01);                              // C9
    chk(2'd1, 8'h20, 1'b0, "e_c10");
    chk(2'd1, 8'h21, 1'b0, "e_c11");
    chk(2'd1, 8'h21, 1'b0, "e_c12");
    idle(7);                                          // C13..C19
    chk(2'd1, 8'h21, 1'b0, "e_c20");
    chk(2'd3, 8'hF9, 1'b0, "e_tac");

    // G: TIMA write coincident with a tick wins
    setup();
    wr_reg(2'd1, 8'h10);
    wr_reg(2'd3, 8'h05);
    idle(14);                                         // C2..C15
    step(1'b1, 2'd1, 8'h80, 1'b1, 8'h10, 1'b0, 1'b1, ST_RUN, "g_tick_write");
    chk_st(2'd1, 8'h80, 1'b0, ST_RUN, "g_c17");
    chk_st(2'd1, 8'h80, 1'b0, ST_RUN, "g_c18");

    // F: reset in OVF with a coincident TIMA write
    setup();
    wr_reg(2'd2, 8'h99);
    wr_reg(2'd1, 8'hFF);
    wr_reg(2'd3, 8'h05);
    idle(14);                                         // C3..C16
    chk_st(2'd1, 8'h00, 1'b0, ST_OVF, "f_ovf");
    reset = 1'b1;
    wr_reg(2'd1, 8'h55);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      logic [15:0] dv;
      logic [1:0]  a;
      logic [7:0]  e;
      dv = INIT_DIV + 16'(k);
      a  = 2'(k % 4);
      case (a)
        2'd0:    e = dv[15:8];
        2'd3:    e = 8'hF8;
        default: e = 8'h00;
      endcase
      chk_st(a, e, 1'b0, ST_RUN, "f_post_reset");
    end

    idle(2);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: %0d expected entries never compared, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before end of stimulus");
    $fatal(1, "watchdog");
  end

endmodule
